// File: rtl/sfifo_pkt_arbiter.sv
// sfifo_pkt_arbiter
// Shares the slow FIFO write port between the event packer and the
// housekeeping packer. Requests are latched, arbitrated with event priority
// plus a starvation guard, and each granted packet is streamed atomically as
// consecutive words with one registered data stage.

module sfifo_pkt_arbiter #(
  parameter int SFIFO_WIDTH = 32,
  parameter int LEN_W       = 6,
  parameter int MAX_LEN     = 32,
  parameter int STARVE_LIM  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   evt_req,
  input  logic [LEN_W-1:0]       evt_len,
  input  logic [SFIFO_WIDTH-1:0] evt_data,
  input  logic                   hk_req,
  input  logic [LEN_W-1:0]       hk_len,
  input  logic [SFIFO_WIDTH-1:0] hk_data,
  input  logic                   sfifo_prog_full,
  output logic                   sfifo_wr,
  output logic [SFIFO_WIDTH-1:0] sfifo_din,
  output logic [LEN_W-1:0]       word_idx,
  output logic                   evt_grant,
  output logic                   hk_grant,
  output logic                   evt_done,
  output logic                   hk_done,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int              STARVE_W  = $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);
  localparam logic [LEN_W-1:0]    MAX_LEN_V  = LEN_W'(MAX_LEN);

  // Registered state
  logic [1:0]             state_q,    state_d;
  logic                   sel_hk_q,   sel_hk_d;     // source of the packet in flight
  logic                   evt_pend_q, evt_pend_d;
  logic                   hk_pend_q,  hk_pend_d;
  logic [LEN_W-1:0]       evt_len_q,  evt_len_d;
  logic [LEN_W-1:0]       hk_len_q,   hk_len_d;
  logic [LEN_W-1:0]       word_idx_q, word_idx_d;
  logic [STARVE_W-1:0]    starve_q,   starve_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   sfifo_wr_q, sfifo_wr_d;
  logic [SFIFO_WIDTH-1:0] sfifo_din_q, sfifo_din_d;
  logic                   evt_done_q, evt_done_d;
  logic                   hk_done_q,  hk_done_d;

  // Decode helpers
  logic [LEN_W-1:0] cur_len;
  logic             last_word;
  logic             evt_clear, hk_clear;
  logic             evt_len_ok, hk_len_ok;
  logic             evt_accept, hk_accept;
  logic             evt_drop, hk_drop;
  logic             grant_go, pick_hk;
  logic [16:0]      drop_sum;

  // Request qualification, end-of-packet detect and arbitration decision.
  // NOTE: every signal written in an always_comb block receives a value on
  // every path (defaults first) so no latch is inferred.
  always_comb begin
    cur_len    = sel_hk_q ? hk_len_q : evt_len_q;
    last_word  = (state_q == ST_SEND) && (word_idx_q == cur_len - LEN_W'(1));
    evt_clear  = last_word && !sel_hk_q;
    hk_clear   = last_word &&  sel_hk_q;

    evt_len_ok = (evt_len != '0) && (evt_len <= MAX_LEN_V);
    hk_len_ok  = (hk_len  != '0) && (hk_len  <= MAX_LEN_V);

    // A source may re-request in the cycle its pending flag is released.
    evt_accept = evt_req && evt_len_ok && (!evt_pend_q || evt_clear);
    hk_accept  = hk_req  && hk_len_ok  && (!hk_pend_q  || hk_clear);
    evt_drop   = evt_req && !evt_accept;
    hk_drop    = hk_req  && !hk_accept;

    grant_go   = (state_q == ST_IDLE) && !sfifo_prog_full && (evt_pend_q || hk_pend_q);
    pick_hk    = hk_pend_q && (!evt_pend_q || (starve_q >= STARVE_MAX));

    drop_sum   = {1'b0, drop_cnt_q} + 17'(evt_drop) + 17'(hk_drop);
  end

  // Next-state logic for the FSM, pending latches, counters and write stage.
  always_comb begin
    state_d     = state_q;
    sel_hk_d    = sel_hk_q;
    word_idx_d  = word_idx_q;
    starve_d    = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_go) begin
          state_d    = ST_SEND;
          sel_hk_d   = pick_hk;
          word_idx_d = '0;
          if (pick_hk) begin
            starve_d = '0;
          end else if (hk_pend_q && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (last_word) begin
          state_d    = ST_GAP;
          word_idx_d = '0;
        end else begin
          word_idx_d = word_idx_q + LEN_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pending flags cover both "waiting" and "being sent"; a fresh accept
    // in the release cycle wins over the clear.
    evt_pend_d = evt_accept ? 1'b1 : (evt_clear ? 1'b0 : evt_pend_q);
    hk_pend_d  = hk_accept  ? 1'b1 : (hk_clear  ? 1'b0 : hk_pend_q);
    evt_len_d  = evt_accept ? evt_len : evt_len_q;
    hk_len_d   = hk_accept  ? hk_len  : hk_len_q;

    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // Word k is captured while word_idx=k and written on the next cycle.
    sfifo_wr_d  = (state_q == ST_SEND);
    sfifo_din_d = sfifo_din_q;
    if (state_q == ST_SEND) begin
      sfifo_din_d = sel_hk_q ? hk_data : evt_data;
    end
    evt_done_d = evt_clear;
    hk_done_d  = hk_clear;
  end

  // State registers with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_hk_q    <= 1'b0;
      evt_pend_q  <= 1'b0;
      hk_pend_q   <= 1'b0;
      evt_len_q   <= '0;
      hk_len_q    <= '0;
      word_idx_q  <= '0;
      starve_q    <= '0;
      drop_cnt_q  <= '0;
      sfifo_wr_q  <= 1'b0;
      sfifo_din_q <= '0;
      evt_done_q  <= 1'b0;
      hk_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_hk_q    <= sel_hk_d;
      evt_pend_q  <= evt_pend_d;
      hk_pend_q   <= hk_pend_d;
      evt_len_q   <= evt_len_d;
      hk_len_q    <= hk_len_d;
      word_idx_q  <= word_idx_d;
      starve_q    <= starve_d;
      drop_cnt_q  <= drop_cnt_d;
      sfifo_wr_q  <= sfifo_wr_d;
      sfifo_din_q <= sfifo_din_d;
      evt_done_q  <= evt_done_d;
      hk_done_q   <= hk_done_d;
    end
  end

  assign sfifo_wr  = sfifo_wr_q;
  assign sfifo_din = sfifo_din_q;
  assign word_idx  = word_idx_q;
  assign evt_grant = (state_q == ST_SEND) && !sel_hk_q;
  assign hk_grant  = (state_q == ST_SEND) &&  sel_hk_q;
  assign evt_done  = evt_done_q;
  assign hk_done   = hk_done_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = evt_pend_q || hk_pend_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfifo_pkt_arbiter.sv
// Directed testbench for sfifo_pkt_arbiter: single packets, simultaneous
// requests, backpressure, starvation guard, drops/saturation, reset mid-packet.

module tb_sfifo_pkt_arbiter;

  logic        clk;
  logic        rst_n;
  logic        evt_req;
  logic [5:0]  evt_len;
  logic [31:0] evt_data;
  logic        hk_req;
  logic [5:0]  hk_len;
  logic [31:0] hk_data;
  logic        sfifo_prog_full;
  logic        sfifo_wr;
  logic [31:0] sfifo_din;
  logic [5:0]  word_idx;
  logic        evt_grant;
  logic        hk_grant;
  logic        evt_done;
  logic        hk_done;
  logic [15:0] drop_cnt;
  logic        busy;

  sfifo_pkt_arbiter #(
    .SFIFO_WIDTH(32), .LEN_W(6), .MAX_LEN(32), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .evt_req(evt_req), .evt_len(evt_len), .evt_data(evt_data),
    .hk_req(hk_req), .hk_len(hk_len), .hk_data(hk_data),
    .sfifo_prog_full(sfifo_prog_full),
    .sfifo_wr(sfifo_wr), .sfifo_din(sfifo_din), .word_idx(word_idx),
    .evt_grant(evt_grant), .hk_grant(hk_grant),
    .evt_done(evt_done), .hk_done(hk_done),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  // Packer models: the word for an index is a fixed pattern per source.
  assign evt_data = {16'hE7E7, 10'h000, word_idx};
  assign hk_data  = {16'h4B4B, 10'h155, word_idx};

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        ed;
    logic        hd;
    int          c;
  } wr_t;

  wr_t   wq[$];
  string seq = "";

  // Write and done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sfifo_wr) wq.push_back('{d: sfifo_din, ed: evt_done, hd: hk_done, c: cyc});
      if (evt_done) seq = {seq, "E"};
      if (hk_done)  seq = {seq, "H"};
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_drops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input bit hk, input int k);
    logic [5:0] kk;
    kk = k[5:0];
    return hk ? {16'h4B4B, 10'h155, kk} : {16'hE7E7, 10'h000, kk};
  endfunction

  // Pulse request inputs for one cycle; called at a negedge.
  task automatic req(input bit e, input bit h, input int el, input int hl);
    evt_req = e;
    hk_req  = h;
    evt_len = el[5:0];
    hk_len  = hl[5:0];
    @(negedge clk);
    evt_req = 1'b0;
    hk_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_word(input string tag, input int idx, input int budget);
    int n = 0;
    while (!(evt_grant && word_idx == idx[5:0]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach_word"}, (evt_grant && word_idx == idx[5:0]), 1'b1);
  endtask

  // Checks one packet in the write log: data, contiguity and done flags.
  task automatic check_pkt(input string tag, input int start, input int len, input bit hk);
    for (int k = 0; k < len; k++) begin
      if (start + k < wq.size()) begin
        check($sformatf("%s_d%0d", tag, k), wq[start+k].d, exp_word(hk, k));
        check($sformatf("%s_c%0d", tag, k), wq[start+k].c, wq[start].c + k);
        check($sformatf("%s_ed%0d", tag, k), wq[start+k].ed, (!hk && k == len - 1));
        check($sformatf("%s_hd%0d", tag, k), wq[start+k].hd, (hk && k == len - 1));
      end
    end
  endtask

  int    rc;
  int    evt_issued;
  int    hk_issued;
  int    n;
  string exp_seq;

  initial begin
    rst_n = 1'b0;
    evt_req = 1'b0; hk_req = 1'b0;
    evt_len = '0;   hk_len = '0;
    sfifo_prog_full = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr", sfifo_wr, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_din", sfifo_din, 0);
    check("rst_idx", word_idx, 0);
    check("rst_grants", {evt_grant, hk_grant, evt_done, hk_done}, 0);
    check("rst_drop", drop_cnt, 0);

    // Single event packet, 16 words, latency 3
    wq.delete();
    rc = cyc;
    req(1, 0, 16, 0);
    check("single_busy", busy, 1);
    wait_idle("single", 60);
    check("single_nw", wq.size(), 16);
    if (wq.size() > 0) check("single_lat", wq[0].c - rc, 3);
    check_pkt("single", 0, 16, 0);

    // Simultaneous requests: event first, then housekeeping
    wq.delete();
    req(1, 1, 16, 4);
    wait_idle("simul", 80);
    check("simul_nw", wq.size(), 20);
    check_pkt("simul_e", 0, 16, 0);
    check_pkt("simul_h", 16, 4, 1);
    check("simul_drop", drop_cnt, 0);

    // Backpressure before start, ignored once started
    wq.delete();
    sfifo_prog_full = 1'b1;
    req(1, 0, 8, 0);
    repeat (5) @(negedge clk);
    check("bp_nw", wq.size(), 0);
    check("bp_busy", busy, 1);
    rc = cyc;
    sfifo_prog_full = 1'b0;
    repeat (3) @(negedge clk);
    sfifo_prog_full = 1'b1;
    wait_idle("bp", 40);
    sfifo_prog_full = 1'b0;
    check("bp_nw2", wq.size(), 8);
    if (wq.size() > 0) check("bp_lat", wq[0].c - rc, 2);
    check_pkt("bp", 0, 8, 0);

    // Starvation guard: evt re-requested on each evt_done
    seq = "";
    evt_issued = 1;
    hk_issued  = 1;
    req(1, 1, 2, 1);
    n = 0;
    while (seq.len() < 11 && n < 400) begin
      evt_req = 1'b0;
      hk_req  = 1'b0;
      if (evt_done && evt_issued < 9) begin
        evt_req = 1'b1; evt_len = 6'd2; evt_issued++;
      end
      if (hk_done && hk_issued < 2) begin
        hk_req = 1'b1; hk_len = 6'd1; hk_issued++;
      end
      @(negedge clk);
      n++;
    end
    evt_req = 1'b0;
    hk_req  = 1'b0;
    wait_idle("starve", 40);
    exp_seq = "EEEEHEEEEHE";
    check("starve_len", seq.len(), exp_seq.len());
    for (int k = 0; k < exp_seq.len(); k++) begin
      if (k < seq.len()) check($sformatf("starve_pkt%0d", k), seq[k], exp_seq[k]);
    end
    check("starve_drop", drop_cnt, 0);

    // Re-request in the last SEND cycle is accepted
    wq.delete();
    req(1, 0, 3, 0);
    wait_word("lastcyc", 2, 20);
    req(1, 0, 3, 0);
    wait_idle("lastcyc", 40);
    check("lastcyc_nw", wq.size(), 6);
    check_pkt("lastcyc_a", 0, 3, 0);
    check_pkt("lastcyc_b", 3, 3, 0);
    check("lastcyc_drop", drop_cnt, 0);

    // Drops: same source busy, length 0, length 33
    wq.delete();
    req(1, 0, 8, 0);
    repeat (3) @(negedge clk);
    req(1, 0, 4, 0);
    exp_drops = 1;
    wait_idle("drop", 40);
    check("drop_busy_cnt", drop_cnt, exp_drops);
    req(1, 0, 0, 0);
    req(1, 0, 33, 0);
    exp_drops = 3;
    wait_idle("drop_len", 10);
    check("drop_len_cnt", drop_cnt, exp_drops);
    check("drop_nw", wq.size(), 8);
    check_pkt("drop", 0, 8, 0);
    req(1, 1, 40, 0);
    exp_drops = 5;
    check("drop_dual", drop_cnt, exp_drops);

    // MAX_LEN boundary is accepted
    wq.delete();
    req(0, 1, 0, 32);
    wait_idle("max", 80);
    check("max_nw", wq.size(), 32);
    check_pkt("max", 0, 32, 1);
    check("max_drop", drop_cnt, exp_drops);

    // Saturation: 32764 dual drops bring 5 up to 16'hFFFD
    for (int i = 0; i < 32764; i++) req(1, 1, 0, 0);
    check("sat_fffd", drop_cnt, 16'hFFFD);
    req(1, 0, 0, 0);
    check("sat_fffe", drop_cnt, 16'hFFFE);
    req(1, 1, 0, 0);
    check("sat_ffff_a", drop_cnt, 16'hFFFF);
    req(1, 1, 0, 0);
    check("sat_ffff_b", drop_cnt, 16'hFFFF);

    // Reset mid-packet at word 7
    req(1, 0, 16, 0);
    wait_word("rstmid", 7, 20);
    rst_n = 1'b0;
    #1;
    check("rstmid_wr", sfifo_wr, 0);
    check("rstmid_din", sfifo_din, 0);
    check("rstmid_idx", word_idx, 0);
    check("rstmid_flags", {evt_grant, hk_grant, evt_done, hk_done, busy}, 0);
    check("rstmid_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    rc = cyc;
    req(1, 0, 5, 0);
    wait_idle("postrst", 30);
    check("postrst_nw", wq.size(), 5);
    if (wq.size() > 0) check("postrst_lat", wq[0].c - rc, 3);
    check_pkt("postrst", 0, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfifo_pkt_arbiter.md
Name: sfifo_pkt_arbiter

Overview:
- Shares the slow FIFO write port between two packet sources: the event packer and a housekeeping/status packer.
- Latches one-clock packet requests and arbitrates between them, with event priority and a starvation guard for housekeeping.
- Streams each granted packet atomically as consecutive 32-bit words into the slow FIFO, honouring prog_full backpressure before a packet starts.
- Sits in the 10 MHz clk domain between the packers and the slow FIFO write side.

Parameters:
- SFIFO_WIDTH, 32, FIFO word width.
- LEN_W, 6, width of packet length and word index.
- MAX_LEN, 32, largest legal packet length in words.
- STARVE_LIM, 4, consecutive event grants allowed while housekeeping is pending.

Ports:
- clk  in  1  processing clock, 10 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- evt_req  in  1  one-clk pulse: event packet ready.
- evt_len  in  LEN_W  event packet length in words, sampled with evt_req.
- evt_data  in  SFIFO_WIDTH  event word selected by word_idx, combinational from the packer.
- hk_req  in  1  one-clk pulse: housekeeping packet ready.
- hk_len  in  LEN_W  housekeeping packet length, sampled with hk_req.
- hk_data  in  SFIFO_WIDTH  housekeeping word selected by word_idx.
- sfifo_prog_full  in  1  slow FIFO prog_full flag.
- sfifo_wr  out  1  slow FIFO write enable.
- sfifo_din  out  SFIFO_WIDTH  slow FIFO write data.
- word_idx  out  LEN_W  index of the word requested from the granted source.
- evt_grant  out  1  high while an event packet is being read.
- hk_grant  out  1  high while a housekeeping packet is being read.
- evt_done  out  1  one-clk pulse on the last event word write.
- hk_done  out  1  one-clk pulse on the last housekeeping word write.
- drop_cnt  out  16  saturating count of dropped requests.
- busy  out  1  high when any packet is pending or in transfer.

Behaviour:
- Reset (rst_n low, asynchronous) drives every output and internal register to 0:
  - state=IDLE, pending flags cleared, starve counter 0, drop_cnt 0.
  - Reset during a transfer abandons the packet; the FIFO keeps any partial words.
- Request latch:
  - evt_req sets evt_pend and captures evt_len; hk_req does the same for hk_pend and hk_len.
  - A request is dropped and drop_cnt increments (saturating at 16'hFFFF) when any of these hold: the same source is already pending or granted; length is 0; length exceeds MAX_LEN.
  - When evt_req and hk_req arrive in the same cycle, both are latched, and drops from both count +2.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If sfifo_prog_full=0 and a request is pending, grant one source and go to SEND with word_idx=0.
  - Selection: event wins, unless hk_pend=1 and the starve counter has reached STARVE_LIM, in which case housekeeping wins.
  - If sfifo_prog_full=1, stay in IDLE and keep requests pending.
- Starve counter:
  - Increments on each event grant made while hk_pend=1.
  - Clears on a housekeeping grant.
- SEND:
  - The grant output for the selected source is high; word_idx increments by 1 every cycle from 0 to len-1.
  - The selected data input is registered, so the word for index k appears on sfifo_din with sfifo_wr=1 exactly one cycle after word_idx=k.
  - No bubbles are inserted; prog_full is ignored once a packet starts, because the FIFO threshold guarantees room for MAX_LEN words.
  - On the cycle word_idx=len-1, the FSM goes to GAP, the grant drops and the pending flag clears.
  - A new request from the same source in that cycle is accepted, not dropped.
- GAP:
  - The final word is written, and evt_done/hk_done pulses in the same cycle as that write.
  - Next state is always IDLE, giving a minimum of one idle clk between packets.
- Latency: request to first sfifo_wr is 3 cycles with the FIFO not full (latch, grant, write).
- busy = evt_pend | hk_pend | (state != IDLE).

Test Plan:
- Single event: evt_req with evt_len=16, prog_full=0 -> sfifo_wr high for 16 consecutive cycles, words equal evt_data at indices 0..15 in order, evt_done on the 16th write, first write 3 cycles after the request.
- Simultaneous requests: evt_req and hk_req (len 4) in the same cycle -> the 16-word event packet goes first, one gap cycle, then 4 housekeeping words; drop_cnt stays 0.
- Backpressure: prog_full=1, then evt_req -> no writes, busy=1; release prog_full -> the packet starts 2 cycles later. Raising prog_full mid-packet does not stall the packet.
- Starvation guard: hk pending while evt_req repeats after every evt_done, STARVE_LIM=4 -> exactly 4 event packets, then the housekeeping packet, then the counter restarts.
- Drops: second evt_req during an event transfer, evt_len=0, and evt_len=33 -> drop_cnt=3, no extra writes; forcing drop_cnt near 16'hFFFF -> it saturates at 16'hFFFF.
- Reset mid-packet: rst_n low at word 7 -> all outputs 0 immediately, FSM in IDLE, nothing pending; a new request after reset is served normally.
